// File: rtl/io_in_conditioner_pkg.sv
// Shared defaults and helpers for the board input conditioner (switches + keys -> 13-bit io_in).
package io_in_conditioner_pkg;

    localparam int SW_W_DEF      = 10;
    localparam int KEY_W_DEF     = 3;
    localparam int IO_W_DEF      = SW_W_DEF + KEY_W_DEF;
    localparam int DB_CYCLES_DEF = 50000;
    localparam int DB_CYCLES_MAX = 1 << 20;

    // Polarity of the raw pin; active-low pins are inverted after synchronization.
    typedef enum logic {
        POL_ACTIVE_HIGH = 1'b0,
        POL_ACTIVE_LOW  = 1'b1
    } pol_e;

    // Counter width for a debounce window of the given length.
    function automatic int db_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/io_in_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer, stable-value register with restart-on-bounce counter,
// and registered rise/fall pulses of the debounced level.
module debounce_bit
    import io_in_conditioner_pkg::*;
#(
    parameter int   DB_CYCLES = DB_CYCLES_DEF,
    parameter pol_e POL       = POL_ACTIVE_HIGH
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = db_cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST     = CW'(DB_CYCLES - 1);
    localparam logic          IDLE_RAW = (POL == POL_ACTIVE_LOW);

    logic [1:0]    sync;
    logic          sample;
    logic [CW-1:0] cnt;

    // NOTE: state uses non-blocking assignments and every register, including the
    // synchronizer pair, gets an explicit reset value so no X reaches the counter.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            sync <= {2{IDLE_RAW}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign sample = (POL == POL_ACTIVE_LOW) ? ~sync[1] : sync[1];

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Full window of agreement: accept the new value and restart.
                level <= sample;
                cnt   <= '0;
                rise  <= sample;
                fall  <= ~sample;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_in_conditioner.sv
// Debounces slide switches and active-low push keys into the processor's io_in word
// ({keys, switches}) and reports one-cycle key press/release pulses.
module io_in_conditioner
    import io_in_conditioner_pkg::*;
#(
    parameter int SW_W      = SW_W_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [SW_W-1:0]         sw_raw,
    input  logic [KEY_W-1:0]        key_raw_n,
    output logic [SW_W+KEY_W-1:0]   io_in,
    output logic [KEY_W-1:0]        key_press,
    output logic [KEY_W-1:0]        key_release
);

    localparam int IO_W = SW_W + KEY_W;

    logic [IO_W-1:0] raw_all;
    logic [IO_W-1:0] rise_all;
    logic [IO_W-1:0] fall_all;
    logic            unused_sw_edges;

    assign raw_all = {key_raw_n, sw_raw};

    for (genvar i = 0; i < IO_W; i++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .POL       ((i >= SW_W) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH)
        ) u_db (
            .clock  (clock),
            .resetn (resetn),
            .raw    (raw_all[i]),
            .level  (io_in[i]),
            .rise   (rise_all[i]),
            .fall   (fall_all[i])
        );
    end

    assign key_press   = rise_all[IO_W-1:SW_W];
    assign key_release = fall_all[IO_W-1:SW_W];

    // Switch edges exist in every bit slice but are not exported.
    assign unused_sw_edges = ^{rise_all[SW_W-1:0], fall_all[SW_W-1:0]};

endmodule

// File: doc/io_in_conditioner.md
IO_IN_CONDITIONER -- requirements
Module: io_in_conditioner

Interface
REQ-001 SHALL have parameter SW_W, default 10: number of slide-switch inputs.
REQ-002 SHALL have parameter KEY_W, default 3: number of push-key inputs.
REQ-003 SHALL have parameter DB_CYCLES, default 50000: debounce window in clocks; legal range 1..2^20.
REQ-004 SHALL have port clock, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: asynchronous reset, active-high despite the name (1 = reset asserted).
REQ-006 SHALL have port sw_raw, input, SW_W: asynchronous switch levels, 1 = on.
REQ-007 SHALL have port key_raw_n, input, KEY_W: asynchronous key levels, active-low (0 = pressed).
REQ-008 SHALL have port io_in, output, SW_W+KEY_W: {key_db, sw_db}, feeds the processor's 13-bit io_in.
REQ-009 SHALL have port key_press, output, KEY_W: one-cycle pulse per debounced key press.
REQ-010 SHALL have port key_release, output, KEY_W: one-cycle pulse per debounced key release.

Function
REQ-011 SHALL pass every raw bit through a 2-flop synchronizer before any other logic.
REQ-012 SHALL invert keys after synchronization, so key_db = 1 means pressed.
REQ-013 SHALL debounce each bit independently: a stable register s and a counter c.
REQ-014 SHALL clear c to 0 in any cycle where the synchronized bit equals s.
REQ-015 SHALL increment c in each cycle where the synchronized bit differs from s.
REQ-016 SHALL, when the bit differs and c = DB_CYCLES-1, load s with the new value and clear c in the same edge.
REQ-017 SHALL give a raw-to-io_in latency of exactly 2 + DB_CYCLES clocks for a clean step.
REQ-018 SHALL discard a glitch lasting fewer than DB_CYCLES synchronized cycles: s unchanged, c returns to 0.
REQ-019 SHALL restart the count from 0 when the bit bounces back to s mid-window; there is no partial credit.
REQ-020 SHALL never wrap c; width = clog2(DB_CYCLES)+1, and c never exceeds DB_CYCLES-1.
REQ-021 SHALL, with DB_CYCLES = 1, update s on the first differing cycle (latency 3).
REQ-022 SHALL register key_press[i] = 1 for exactly the one cycle after key_db[i] goes 0->1; key_release likewise on 1->0.
REQ-023 SHALL let simultaneous transitions on different bits proceed independently, with no arbitration.
REQ-024 SHALL drive io_in directly from the s registers, with no extra combinational path from raw inputs.

Reset
REQ-025 SHALL, while resetn = 1, asynchronously force: switch sync flops 0, key sync flops 1 (released), all s 0, all c 0, io_in 0, key_press 0, key_release 0.
REQ-026 SHALL, on reset release with a key held, report the press only after a full 2 + DB_CYCLES window, and pulse key_press once.
REQ-027 SHALL, on reset asserted mid-window, abandon the pending count; no pulse occurs after release.

Structure
REQ-028 SHALL place in a shared include/package: the DB_CYCLES default, the counter-width function, and the SW_W/KEY_W defaults matching the processor's 13-bit io_in.
REQ-029 SHALL implement one sub-module, debounce_bit (sync pair, s, c, edge pulses), instantiated SW_W+KEY_W times via generate.

Verification (DB_CYCLES = 4 in the bench)
REQ-030 SHALL cover: sw_raw[0] 0->1 held steady -> io_in[0] = 1 exactly 6 clocks later; other bits remain 0.
REQ-031 SHALL cover: key_raw_n[1] low for 3 cycles, then high -> io_in[11] stays 0, key_press stays 0, c back to 0.
REQ-032 SHALL cover: key_raw_n[2] held low 20 cycles, then high 20 cycles -> io_in[12] high from cycle 6; one key_press[2] pulse; one key_release[2] pulse 6 clocks after release.
REQ-033 SHALL cover: bounce pattern 0,1,1,0,1,1,1,1 on sw_raw[3] -> io_in[3] rises 2+4 clocks after the last 0->1 edge.
REQ-034 SHALL cover: resetn pulsed at cycle 3 of a 4-cycle window with sw_raw[5] high -> io_in = 0 during reset; io_in[5] = 1 exactly 6 clocks after reset release.
REQ-035 SHALL cover: all 13 inputs toggled in the same cycle -> io_in changes on all bits in one edge, 6 clocks later; all three key pulses coincide.
